// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//
// Instruction buffer sitting between fetch and decode. Accepts a fetch batch of
// up to BATCH lanes per cycle (sparse valid mask allowed), packs the valid lanes
// contiguously into a circular store, and presents the two oldest entries to
// decode in program order. A flush empties the buffer in one cycle.
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   rst                 synchronous active-high reset (priority over flush)
//   flush               discard all contents this cycle
//   in_inst_0..3        fetched instruction per lane, lane 0 oldest
//   in_pc_0..3          PC per lane
//   in_inst_valid       lane valid mask, may be non-contiguous
//   in_ready            buffer can take a full batch this cycle
//   out_inst_0/1        entries at head and head+1
//   out_pc_0/1          matching PCs
//   out_valid           bit i set when entry head+i exists
//   dec_accept          decode consumes slot i (only as a prefix of valid slots)
//   count               current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef IF_BATCH_SIZE
`define IF_BATCH_SIZE 4
`endif

module inst_buffer #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = `INST_ADDR_WIDTH,
    parameter int BATCH      = `IF_BATCH_SIZE,
    parameter int DEQ_WIDTH  = 2,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [INST_WIDTH-1:0]        in_inst_0,
    input  logic [INST_WIDTH-1:0]        in_inst_1,
    input  logic [INST_WIDTH-1:0]        in_inst_2,
    input  logic [INST_WIDTH-1:0]        in_inst_3,
    input  logic [ADDR_WIDTH-1:0]        in_pc_0,
    input  logic [ADDR_WIDTH-1:0]        in_pc_1,
    input  logic [ADDR_WIDTH-1:0]        in_pc_2,
    input  logic [ADDR_WIDTH-1:0]        in_pc_3,
    input  logic [BATCH-1:0]             in_inst_valid,
    output logic                         in_ready,
    output logic [INST_WIDTH-1:0]        out_inst_0,
    output logic [INST_WIDTH-1:0]        out_inst_1,
    output logic [ADDR_WIDTH-1:0]        out_pc_0,
    output logic [ADDR_WIDTH-1:0]        out_pc_1,
    output logic [DEQ_WIDTH-1:0]         out_valid,
    input  logic [DEQ_WIDTH-1:0]         dec_accept,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LANE_W = $clog2(BATCH + 1);
    localparam int DEQ_W  = $clog2(DEQ_WIDTH + 1);

    // Circular store, one word per entry.
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    // Per-lane views of the flat input ports.
    logic [INST_WIDTH-1:0] lane_inst [BATCH];
    logic [ADDR_WIDTH-1:0] lane_pc   [BATCH];

    assign lane_inst[0] = in_inst_0;
    assign lane_inst[1] = in_inst_1;
    assign lane_inst[2] = in_inst_2;
    assign lane_inst[3] = in_inst_3;
    assign lane_pc[0]   = in_pc_0;
    assign lane_pc[1]   = in_pc_1;
    assign lane_pc[2]   = in_pc_2;
    assign lane_pc[3]   = in_pc_3;

    // lane_off[i] = number of valid lanes below lane i, i.e. the slot offset
    // from tail where lane i lands. lane_off[BATCH] is the enqueue count.
    logic [LANE_W-1:0] lane_off [BATCH+1];
    logic [LANE_W-1:0] n_enq;
    logic              enq_fire;
    logic [PTR_W-1:0]  wr_addr [BATCH];

    always_comb begin
        lane_off[0] = '0;
        for (int i = 0; i < BATCH; i++) begin
            lane_off[i+1] = lane_off[i] + LANE_W'(in_inst_valid[i]);
        end
    end

    assign n_enq = lane_off[BATCH];

    generate
        for (genvar gi = 0; gi < BATCH; gi++) begin : g_wr_addr
            assign wr_addr[gi] = tail_reg + PTR_W'(lane_off[gi]);
        end
    endgenerate

    // Threshold uses the registered count only, so a full batch always has
    // room even before any same-cycle dequeue is credited.
    assign in_ready = !rst && !flush && (count_reg <= CNT_W'(DEPTH - BATCH));
    assign enq_fire = in_ready && (|in_inst_valid);

    // Compacting write: only valid lanes are stored, in ascending lane order.
    // in_ready guarantees these slots are free, so no live entry is touched.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < BATCH; i++) begin
                if (in_inst_valid[i]) begin
                    inst_mem[wr_addr[i]] <= lane_inst[i];
                    pc_mem[wr_addr[i]]   <= lane_pc[i];
                end
            end
        end
    end

    // Output side: combinational reads at head and head+1.
    logic [PTR_W-1:0] rd_addr_1;
    assign rd_addr_1  = head_reg + PTR_W'(1);
    assign out_inst_0 = inst_mem[head_reg];
    assign out_pc_0   = pc_mem[head_reg];
    assign out_inst_1 = inst_mem[rd_addr_1];
    assign out_pc_1   = pc_mem[rd_addr_1];

    generate
        for (genvar gi = 0; gi < DEQ_WIDTH; gi++) begin : g_out_valid
            assign out_valid[gi] = !rst && (count_reg > CNT_W'(gi));
        end
    endgenerate

    // Accepted slots must form a prefix: a later slot counts only if every
    // earlier slot was also accepted.
    logic             acc_prefix;
    logic [DEQ_W-1:0] n_deq;

    always_comb begin
        acc_prefix = 1'b1;
        n_deq      = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            acc_prefix = acc_prefix & dec_accept[i] & out_valid[i];
            n_deq      = n_deq + DEQ_W'(acc_prefix);
        end
    end

    always_comb begin
        head_next  = head_reg + PTR_W'(n_deq);
        tail_next  = enq_fire ? (tail_reg + PTR_W'(n_enq)) : tail_reg;
        count_next = count_reg + (enq_fire ? CNT_W'(n_enq) : CNT_W'(0)) - CNT_W'(n_deq);
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int BATCH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [IW-1:0] in_inst_0, in_inst_1, in_inst_2, in_inst_3;
    logic [AW-1:0] in_pc_0, in_pc_1, in_pc_2, in_pc_3;
    logic [3:0]    in_inst_valid;
    logic          in_ready;
    logic [IW-1:0] out_inst_0, out_inst_1;
    logic [AW-1:0] out_pc_0, out_pc_1;
    logic [1:0]    out_valid;
    logic [1:0]    dec_accept;
    logic [CW-1:0] count;

    inst_buffer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_inst_0(in_inst_0), .in_inst_1(in_inst_1),
        .in_inst_2(in_inst_2), .in_inst_3(in_inst_3),
        .in_pc_0(in_pc_0), .in_pc_1(in_pc_1), .in_pc_2(in_pc_2), .in_pc_3(in_pc_3),
        .in_inst_valid(in_inst_valid), .in_ready(in_ready),
        .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
        .out_pc_0(out_pc_0), .out_pc_1(out_pc_1),
        .out_valid(out_valid), .dec_accept(dec_accept), .count(count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    // Lane i carries pc = base + 4*i; instruction word derived from the PC.
    task automatic drive(input logic fl, input logic [3:0] mask,
                         input logic [AW-1:0] base, input logic [1:0] acc);
        flush = fl; in_inst_valid = mask; dec_accept = acc;
        in_pc_0 = base;      in_inst_0 = inst_of(base);
        in_pc_1 = base + 4;  in_inst_1 = inst_of(base + 4);
        in_pc_2 = base + 8;  in_inst_2 = inst_of(base + 8);
        in_pc_3 = base + 12; in_inst_3 = inst_of(base + 12);
    endtask

    typedef struct {
        logic          fl;
        logic [3:0]    mask;
        logic [AW-1:0] base;
        logic [1:0]    acc;
        int            e_cnt;
        logic          e_rdy;
        logic [1:0]    e_vld;
        logic [AW-1:0] e_pc0;
        logic [AW-1:0] e_pc1;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic fl, input logic [3:0] mask, input logic [AW-1:0] base,
                                input logic [1:0] acc, input int e_cnt, input logic e_rdy,
                                input logic [1:0] e_vld, input logic [AW-1:0] e_pc0,
                                input logic [AW-1:0] e_pc1);
        vec_t v;
        v.fl = fl; v.mask = mask; v.base = base; v.acc = acc; v.e_cnt = e_cnt;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_pc0 = e_pc0; v.e_pc1 = e_pc1;
        return v;
    endfunction

    // Reference model: a queue of PCs in program order (instruction derived from PC).
    logic [AW-1:0] mq[$];
    logic [AW-1:0] pc_ctr;

    task automatic model_step(input logic fl, input logic [3:0] mask, input logic [1:0] acc);
        logic [1:0] ev;
        logic       er;
        int         sz;
        int         n_deq;
        sz = mq.size();
        er = !fl && (sz <= DEPTH - BATCH);
        ev = {sz >= 2, sz >= 1};
        drive(fl, mask, pc_ctr, acc);
        #1;
        chk("rnd_count", count, sz);
        chk("rnd_in_ready", in_ready, er);
        chk("rnd_out_valid", out_valid, ev);
        if (sz >= 1) begin
            chk("rnd_pc0", out_pc_0, mq[0]);
            chk("rnd_inst0", out_inst_0, inst_of(mq[0]));
        end
        if (sz >= 2) begin
            chk("rnd_pc1", out_pc_1, mq[1]);
            chk("rnd_inst1", out_inst_1, inst_of(mq[1]));
        end
        if (fl) begin
            mq.delete();
        end else begin
            n_deq = 0;
            if (acc[0] && sz >= 1) begin
                n_deq = 1;
                if (acc[1] && sz >= 2) n_deq = 2;
            end
            repeat (n_deq) void'(mq.pop_front());
            if (er) begin
                for (int i = 0; i < BATCH; i++) begin
                    if (mask[i]) mq.push_back(pc_ctr + AW'(4 * i));
                end
            end
        end
        pc_ctr = pc_ctr + 16;
        @(negedge clk);
    endtask

    initial begin
        // Directed sequence: sparse compaction, backpressure, threshold, non-prefix, flush.
        tbl[0]  = mk(0, 4'b1011, 32'h100, 2'b00,  0, 1, 2'b00, 32'h0,   32'h0);
        tbl[1]  = mk(0, 4'b0000, 32'h0,   2'b00,  3, 1, 2'b11, 32'h100, 32'h104);
        tbl[2]  = mk(0, 4'b0000, 32'h0,   2'b11,  3, 1, 2'b11, 32'h100, 32'h104);
        tbl[3]  = mk(0, 4'b0000, 32'h0,   2'b00,  1, 1, 2'b01, 32'h10C, 32'h0);
        tbl[4]  = mk(0, 4'b0000, 32'h0,   2'b01,  1, 1, 2'b01, 32'h10C, 32'h0);
        tbl[5]  = mk(0, 4'b1111, 32'h200, 2'b00,  0, 1, 2'b00, 32'h0,   32'h0);
        tbl[6]  = mk(0, 4'b1111, 32'h210, 2'b00,  4, 1, 2'b11, 32'h200, 32'h204);
        tbl[7]  = mk(0, 4'b1111, 32'h220, 2'b00,  8, 1, 2'b11, 32'h200, 32'h204);
        tbl[8]  = mk(0, 4'b1111, 32'h230, 2'b00, 12, 1, 2'b11, 32'h200, 32'h204);
        tbl[9]  = mk(0, 4'b1111, 32'h240, 2'b00, 16, 0, 2'b11, 32'h200, 32'h204);
        tbl[10] = mk(0, 4'b0000, 32'h0,   2'b11, 16, 0, 2'b11, 32'h200, 32'h204);
        tbl[11] = mk(0, 4'b0000, 32'h0,   2'b11, 14, 0, 2'b11, 32'h208, 32'h20C);
        tbl[12] = mk(0, 4'b0000, 32'h0,   2'b11, 12, 1, 2'b11, 32'h210, 32'h214);
        tbl[13] = mk(0, 4'b0011, 32'h300, 2'b00, 10, 1, 2'b11, 32'h218, 32'h21C);
        tbl[14] = mk(0, 4'b1111, 32'h310, 2'b11, 12, 1, 2'b11, 32'h218, 32'h21C);
        tbl[15] = mk(0, 4'b0000, 32'h0,   2'b01, 14, 0, 2'b11, 32'h220, 32'h224);
        tbl[16] = mk(0, 4'b1111, 32'h400, 2'b11, 13, 0, 2'b11, 32'h224, 32'h228);
        tbl[17] = mk(0, 4'b0000, 32'h0,   2'b10, 11, 1, 2'b11, 32'h22C, 32'h230);
        tbl[18] = mk(0, 4'b0000, 32'h0,   2'b00, 11, 1, 2'b11, 32'h22C, 32'h230);
        tbl[19] = mk(1, 4'b1111, 32'h500, 2'b11, 11, 0, 2'b11, 32'h22C, 32'h230);
        tbl[20] = mk(0, 4'b0000, 32'h0,   2'b00,  0, 1, 2'b00, 32'h0,   32'h0);

        // Reset: held two cycles with activity on the inputs.
        rst = 1'b1;
        drive(0, 4'b1111, 32'hDEAD0000, 2'b11);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_out_valid", out_valid, 2'b00);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 4'b0000, 32'h0, 2'b00);
        #1;
        chk("post_rst_count", count, 0);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 2'b00);

        for (int s = 0; s < 21; s++) begin
            drive(tbl[s].fl, tbl[s].mask, tbl[s].base, tbl[s].acc);
            #1;
            chk($sformatf("vec%0d_count", s), count, tbl[s].e_cnt);
            chk($sformatf("vec%0d_in_ready", s), in_ready, tbl[s].e_rdy);
            chk($sformatf("vec%0d_out_valid", s), out_valid, tbl[s].e_vld);
            if (tbl[s].e_vld[0]) chk($sformatf("vec%0d_pc0", s), out_pc_0, tbl[s].e_pc0);
            if (tbl[s].e_vld[1]) chk($sformatf("vec%0d_pc1", s), out_pc_1, tbl[s].e_pc1);
            $display("vec %0d: flush=%0b mask=%b acc=%b count=%0d ready=%0b valid=%b pc0=%h",
                     s, tbl[s].fl, tbl[s].mask, tbl[s].acc, count, in_ready, out_valid, out_pc_0);
            @(negedge clk);
        end

        // Randomized run against the queue model: covers wrap, sparse masks,
        // partial accepts and occasional flushes.
        mq.delete();
        pc_ctr = 32'h1000;
        for (int t = 0; t < 400; t++) begin
            logic fl;
            logic [3:0] m;
            logic [1:0] a;
            fl = ($urandom_range(0, 31) == 0);
            m  = 4'($urandom);
            a  = 2'($urandom);
            model_step(fl, m, a);
            if (t % 40 == 0)
                $display("rnd %0d: flush=%0b mask=%b acc=%b model_count=%0d", t, fl, m, a, mq.size());
        end

        // Reset overrides flush and a pending batch on a non-empty buffer.
        while (mq.size() < 3) model_step(0, 4'b1111, 2'b00);
        rst = 1'b1;
        drive(1, 4'b1111, 32'h9000, 2'b11);
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_out_valid", out_valid, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 4'b0000, 32'h0, 2'b00);
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ready_after", in_ready, 1'b1);
        $display("mid reset: count=%0d ready=%0b valid=%b", count, in_ready, out_valid);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
